// File: rtl/anchor_scheduler_if.sv
// Signal bundle between the anchor scheduler, the line fetcher and the filter controllers.
// The master modport is the scheduler side; the slave modport is the fetcher/filter side.
interface anchor_scheduler_if #(
  parameter int NUM_STAGES = 3
);
  logic                  start;
  logic                  abort;
  logic [NUM_STAGES-1:0] stage_final;
  logic                  fetch_req;
  logic [31:0]           fetch_row;
  logic [31:0]           fetch_col;
  logic                  fetch_done;
  logic                  anchor_moving;
  logic [31:0]           anchor_x;
  logic [31:0]           anchor_y;
  logic                  busy;
  logic                  frame_done;
  logic                  error;

  modport master (
    input  start, abort, stage_final, fetch_done,
    output fetch_req, fetch_row, fetch_col, anchor_moving,
           anchor_x, anchor_y, busy, frame_done, error
  );

  modport slave (
    output start, abort, stage_final, fetch_done,
    input  fetch_req, fetch_row, fetch_col, anchor_moving,
           anchor_x, anchor_y, busy, frame_done, error
  );
endinterface

// File: rtl/anchor_scheduler.sv
// Frame sequencer: walks the filter anchor over the image strip by strip, fetching each
// line segment and holding each move until every filter stage has reported final.
module anchor_scheduler #(
  parameter int ROWS       = 480,
  parameter int STRIPS     = 40,
  parameter int NUM_STAGES = 3,
  parameter int TIMEOUT    = 1023
) (
  input logic                clk,
  input logic                n_rst,
  anchor_scheduler_if.master bus
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, PRIME, MOVE, HOLD, RUN, DONE, ERR} state_t;

  state_t                state;
  logic [NUM_STAGES-1:0] mask;
  logic [NUM_STAGES-1:0] mask_next;
  logic [TW-1:0]         timer;
  logic                  fetch_complete;
  logic                  fetch_seen;
  logic                  complete_next;
  logic                  all_final;
  logic                  is_last;
  logic                  timed_out;
  logic [31:0]           next_x;
  logic [31:0]           next_y;

  // Completion looks at this cycle's finals and fetch_done so the move follows one cycle later.
  always_comb begin
    fetch_seen    = bus.fetch_req & bus.fetch_done;
    mask_next     = mask | bus.stage_final;
    complete_next = fetch_complete | fetch_seen;
    all_final     = &mask_next;
    is_last       = (bus.anchor_x == 32'(ROWS - 1)) && (bus.anchor_y == 32'(STRIPS - 1));
    timed_out     = (timer == TW'(TIMEOUT));
    if (bus.anchor_x == 32'(ROWS - 1)) begin
      next_x = '0;
      next_y = bus.anchor_y + 32'd1;
    end else begin
      next_x = bus.anchor_x + 32'd1;
      next_y = bus.anchor_y;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state             <= IDLE;
      mask              <= '0;
      timer             <= '0;
      fetch_complete    <= 1'b0;
      bus.fetch_req     <= 1'b0;
      bus.fetch_row     <= '0;
      bus.fetch_col     <= '0;
      bus.anchor_moving <= 1'b0;
      bus.anchor_x      <= '0;
      bus.anchor_y      <= '0;
      bus.busy          <= 1'b0;
      bus.frame_done    <= 1'b0;
      bus.error         <= 1'b0;
    end else begin
      bus.anchor_moving <= 1'b0;
      bus.frame_done    <= 1'b0;
      if (bus.abort && state != IDLE) begin
        state         <= IDLE;
        bus.busy      <= 1'b0;
        bus.fetch_req <= 1'b0;
      end else begin
        case (state)
          IDLE, ERR: begin
            if (state == IDLE) begin
              bus.anchor_x <= '0;
              bus.anchor_y <= '0;
              bus.error    <= 1'b0;
            end
            if (bus.start) begin
              state         <= PRIME;
              bus.busy      <= 1'b1;
              bus.error     <= 1'b0;
              bus.anchor_x  <= '0;
              bus.anchor_y  <= '0;
              bus.fetch_req <= 1'b1;
              bus.fetch_row <= '0;
              bus.fetch_col <= '0;
              timer         <= '0;
            end
          end
          PRIME: begin
            if (fetch_seen) begin
              state             <= MOVE;
              bus.fetch_req     <= 1'b0;
              bus.anchor_moving <= 1'b1;
            end else if (timed_out) begin
              state         <= ERR;
              bus.error     <= 1'b1;
              bus.busy      <= 1'b0;
              bus.fetch_req <= 1'b0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          MOVE: begin
            state <= HOLD;
          end
          // Stages still show final=1 from idle here, so the mask restarts empty.
          HOLD: begin
            state          <= RUN;
            mask           <= '0;
            timer          <= '0;
            fetch_complete <= is_last;
            bus.fetch_req  <= !is_last;
            bus.fetch_row  <= next_x;
            bus.fetch_col  <= next_y << 4;
          end
          RUN: begin
            mask           <= mask_next;
            fetch_complete <= complete_next;
            if (fetch_seen) begin
              bus.fetch_req <= 1'b0;
            end
            if (all_final && complete_next) begin
              if (is_last) begin
                state          <= DONE;
                bus.frame_done <= 1'b1;
              end else begin
                state             <= MOVE;
                bus.anchor_moving <= 1'b1;
                bus.anchor_x      <= next_x;
                bus.anchor_y      <= next_y;
              end
            end else if (timed_out) begin
              state         <= ERR;
              bus.error     <= 1'b1;
              bus.busy      <= 1'b0;
              bus.fetch_req <= 1'b0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          DONE: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
          default: begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.fetch_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_anchor_scheduler.sv
// Self-checking bench for anchor_scheduler: scripted fetcher/filter responses with random
// delays, expected event timing derived from the anchor walk order and latency rules.
module tb_anchor_scheduler;

  localparam int ROWS   = 3;
  localparam int STRIPS = 2;
  localparam int NS     = 3;
  localparam int N_ANCH = ROWS * STRIPS;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  int   cyc         = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   mov_cnt     = 0;
  int   done_cnt    = 0;

  anchor_scheduler_if #(.NUM_STAGES(NS)) bus0 ();
  anchor_scheduler_if #(.NUM_STAGES(NS)) bus1 ();

  anchor_scheduler #(.ROWS(ROWS), .STRIPS(STRIPS), .NUM_STAGES(NS), .TIMEOUT(63)) dut0 (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus0)
  );

  anchor_scheduler #(.ROWS(ROWS), .STRIPS(STRIPS), .NUM_STAGES(NS), .TIMEOUT(15)) dut1 (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters for the main instance, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus0.anchor_moving === 1'b1) mov_cnt++;
    if (bus0.frame_done === 1'b1) done_cnt++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired at cyc=%0d, got running, required finished", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int pick(input int v);
    return (v < 0) ? int'($urandom_range(0, 8)) : v;
  endfunction

  task automatic clear_inputs();
    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.stage_final = '0; bus0.fetch_done = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.stage_final = '0; bus1.fetch_done = 1'b0;
  endtask

  // Plays one frame on dut0. fd/f0..f2 are fetch and stage-final delays counted from RUN entry
  // (-1 = random). kill_idx >= 0 aborts (or resets) one cycle after RUN entry of that anchor.
  task automatic run_frame(input int fd, input int f0, input int f1, input int f2,
                           input bit hold_ones, input bit strays, input bit start_noise,
                           input int kill_idx, input bit kill_rst);
    int pd, t0, r, m, fdl, maxf, nx, ny;
    int fin[3];
    bit last, exp_req;
    tick();
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    pd = pick(fd);
    for (int k = 0; k <= pd; k++) begin
      vectors++;
      if ({bus0.fetch_req, bus0.anchor_moving, bus0.busy, bus0.fetch_row, bus0.fetch_col} !== {3'b101, 64'd0}) begin
        miscompares++;
        $display("[TB] FAIL prime_fetch cyc=%0d got req/mov/busy=%b row=%0d col=%0d, required 101 row=0 col=0",
                 cyc, {bus0.fetch_req, bus0.anchor_moving, bus0.busy}, bus0.fetch_row, bus0.fetch_col);
      end
      bus0.fetch_done = (k == pd);
      tick();
    end
    bus0.fetch_done = 1'b0;
    for (int i = 0; i < N_ANCH; i++) begin
      last = (i == N_ANCH - 1);
      vectors++;
      if ({bus0.anchor_moving, bus0.fetch_req, bus0.frame_done, bus0.anchor_x, bus0.anchor_y} !==
          {3'b100, 32'(i % ROWS), 32'(i / ROWS)}) begin
        miscompares++;
        $display("[TB] FAIL move cyc=%0d anchor=%0d got mov/req/done=%b pos=(%0d,%0d), required 100 pos=(%0d,%0d)",
                 cyc, i, {bus0.anchor_moving, bus0.fetch_req, bus0.frame_done}, bus0.anchor_x, bus0.anchor_y,
                 i % ROWS, i / ROWS);
      end
      t0 = cyc;
      r = t0 + 2;
      fdl = pick(fd);
      fin[0] = pick(f0); fin[1] = pick(f1); fin[2] = pick(f2);
      maxf = fin[0];
      if (fin[1] > maxf) maxf = fin[1];
      if (fin[2] > maxf) maxf = fin[2];
      m = r + maxf;
      if (!last && (r + fdl) > m) m = r + fdl;
      nx = (i + 1) % ROWS;
      ny = (i + 1) / ROWS;
      for (int c = t0 + 1; c <= m; c++) begin
        tick();
        exp_req = !last && (c >= r) && (c <= r + fdl);
        vectors++;
        if ({bus0.fetch_req, bus0.anchor_moving, bus0.frame_done, bus0.busy} !== {exp_req, 3'b001}) begin
          miscompares++;
          $display("[TB] FAIL run_ctl cyc=%0d anchor=%0d got req/mov/done/busy=%b, required %b",
                   cyc, i, {bus0.fetch_req, bus0.anchor_moving, bus0.frame_done, bus0.busy}, {exp_req, 3'b001});
        end
        if (exp_req) begin
          vectors++;
          if ({bus0.fetch_row, bus0.fetch_col} !== {32'(nx), 32'(16 * ny)}) begin
            miscompares++;
            $display("[TB] FAIL fetch_addr cyc=%0d anchor=%0d got row=%0d col=%0d, required row=%0d col=%0d",
                     cyc, i, bus0.fetch_row, bus0.fetch_col, nx, 16 * ny);
          end
        end
        if (i == kill_idx && c == r + 1) begin
          if (kill_rst) n_rst = 1'b0;
          else bus0.abort = 1'b1;
          bus0.stage_final = '0;
          bus0.fetch_done = 1'b0;
          tick();
          n_rst = 1'b1;
          bus0.abort = 1'b0;
          vectors++;
          if (kill_rst) begin
            if ({bus0.fetch_req, bus0.anchor_moving, bus0.busy, bus0.frame_done, bus0.error,
                 bus0.fetch_row, bus0.fetch_col, bus0.anchor_x, bus0.anchor_y} !== '0) begin
              miscompares++;
              $display("[TB] FAIL reset_midframe cyc=%0d got req/mov/busy/done/err=%b row=%0d col=%0d pos=(%0d,%0d), required all 0",
                       cyc, {bus0.fetch_req, bus0.anchor_moving, bus0.busy, bus0.frame_done, bus0.error},
                       bus0.fetch_row, bus0.fetch_col, bus0.anchor_x, bus0.anchor_y);
            end
          end else begin
            if ({bus0.busy, bus0.fetch_req, bus0.anchor_moving, bus0.frame_done} !== 4'b0000) begin
              miscompares++;
              $display("[TB] FAIL abort cyc=%0d got busy/req/mov/done=%b, required 0000",
                       cyc, {bus0.busy, bus0.fetch_req, bus0.anchor_moving, bus0.frame_done});
            end
          end
          for (int k = 0; k < 5; k++) begin
            tick();
            vectors++;
            if ({bus0.busy, bus0.frame_done, bus0.anchor_moving, bus0.fetch_req} !== 4'b0000) begin
              miscompares++;
              $display("[TB] FAIL after_kill cyc=%0d got busy/done/mov/req=%b, required 0000",
                       cyc, {bus0.busy, bus0.frame_done, bus0.anchor_moving, bus0.fetch_req});
            end
          end
          return;
        end
        bus0.stage_final = '0;
        for (int k = 0; k < NS; k++) bus0.stage_final[k] = (c == r + fin[k]);
        if (hold_ones && c == t0 + 1) bus0.stage_final = '1;
        bus0.fetch_done = (!last && c == r + fdl) || (strays && !exp_req && ($urandom_range(0, 1) == 1));
        bus0.start = start_noise && ($urandom_range(0, 1) == 1);
      end
      tick();
      bus0.stage_final = '0;
      bus0.fetch_done = 1'b0;
      bus0.start = 1'b0;
    end
    vectors++;
    if ({bus0.frame_done, bus0.anchor_moving, bus0.busy, bus0.anchor_x, bus0.anchor_y} !==
        {3'b101, 32'(ROWS - 1), 32'(STRIPS - 1)}) begin
      miscompares++;
      $display("[TB] FAIL frame_done cyc=%0d got done/mov/busy=%b pos=(%0d,%0d), required 101 pos=(%0d,%0d)",
               cyc, {bus0.frame_done, bus0.anchor_moving, bus0.busy}, bus0.anchor_x, bus0.anchor_y, ROWS - 1, STRIPS - 1);
    end
    tick();
    vectors++;
    if ({bus0.busy, bus0.frame_done, bus0.fetch_req, bus0.error} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL back_to_idle cyc=%0d got busy/done/req/err=%b, required 0000",
               cyc, {bus0.busy, bus0.frame_done, bus0.fetch_req, bus0.error});
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus0.start = 1'b1; bus0.stage_final = 3'($urandom); bus0.fetch_done = 1'b1; bus0.abort = 1'b0;
    bus1.start = 1'b1; bus1.stage_final = 3'($urandom); bus1.fetch_done = 1'b1; bus1.abort = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({bus0.fetch_req, bus0.anchor_moving, bus0.busy, bus0.frame_done, bus0.error,
         bus0.fetch_row, bus0.fetch_col, bus0.anchor_x, bus0.anchor_y} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_dut0 got req/mov/busy/done/err=%b row=%0d col=%0d pos=(%0d,%0d), required all 0",
               {bus0.fetch_req, bus0.anchor_moving, bus0.busy, bus0.frame_done, bus0.error},
               bus0.fetch_row, bus0.fetch_col, bus0.anchor_x, bus0.anchor_y);
    end
    vectors++;
    if ({bus1.fetch_req, bus1.anchor_moving, bus1.busy, bus1.frame_done, bus1.error,
         bus1.fetch_row, bus1.fetch_col, bus1.anchor_x, bus1.anchor_y} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_dut1 got req/mov/busy/done/err=%b, required all 0",
               {bus1.fetch_req, bus1.anchor_moving, bus1.busy, bus1.frame_done, bus1.error});
    end
    clear_inputs();
    n_rst = 1'b1;
    tick();
    vectors++;
    if ({bus0.busy, bus0.fetch_req, bus1.busy, bus1.fetch_req} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_release got busy0/req0/busy1/req1=%b, required 0000",
               {bus0.busy, bus0.fetch_req, bus1.busy, bus1.fetch_req});
    end
  endtask

  task automatic test_frame_walk();
    int m0, d0;
    #1; m0 = mov_cnt; d0 = done_cnt;
    run_frame(2, 4, 4, 4, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    #1;
    vectors++;
    if ((mov_cnt - m0) != N_ANCH || (done_cnt - d0) != 1) begin
      miscompares++;
      $display("[TB] FAIL walk_counts got moves=%0d dones=%0d, required moves=%0d dones=1",
               mov_cnt - m0, done_cnt - d0, N_ANCH);
    end
  endtask

  task automatic test_out_of_order();
    run_frame(2, 2, 7, 4, 1'b1, 1'b0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_slow_fetch();
    run_frame(20, 3, 3, 3, 1'b0, 1'b1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_start_ignored();
    int m0, d0;
    #1; m0 = mov_cnt; d0 = done_cnt;
    run_frame(1, 3, 4, 2, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    #1;
    vectors++;
    if ((mov_cnt - m0) != N_ANCH || (done_cnt - d0) != 1) begin
      miscompares++;
      $display("[TB] FAIL start_noise_counts got moves=%0d dones=%0d, required moves=%0d dones=1",
               mov_cnt - m0, done_cnt - d0, N_ANCH);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      run_frame(-1, -1, -1, -1, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), -1, 1'b0);
    end
  endtask

  task automatic test_abort();
    int d0;
    #1; d0 = done_cnt;
    run_frame(2, 5, 5, 5, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    #1;
    vectors++;
    if (done_cnt != d0) begin
      miscompares++;
      $display("[TB] FAIL abort_no_done got dones=%0d, required 0", done_cnt - d0);
    end
  endtask

  task automatic test_reset_midframe();
    run_frame(2, 5, 5, 5, 1'b0, 1'b0, 1'b0, 3, 1'b1);
  endtask

  task automatic test_timeout();
    tick();
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    vectors++;
    if ({bus1.fetch_req, bus1.busy, bus1.error} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL to_prime cyc=%0d got req/busy/err=%b, required 110", cyc, {bus1.fetch_req, bus1.busy, bus1.error});
    end
    bus1.fetch_done = 1'b1;
    tick();
    bus1.fetch_done = 1'b0;
    vectors++;
    if (bus1.anchor_moving !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL to_move cyc=%0d got mov=%b, required 1", cyc, bus1.anchor_moving);
    end
    tick();
    bus1.stage_final = '1;
    tick();
    bus1.stage_final = '0;
    for (int j = 0; j <= 15; j++) begin
      vectors++;
      if ({bus1.error, bus1.busy, bus1.fetch_req} !== {2'b01, (j == 0)}) begin
        miscompares++;
        $display("[TB] FAIL to_wait cyc=%0d run+%0d got err/busy/req=%b, required %b",
                 cyc, j, {bus1.error, bus1.busy, bus1.fetch_req}, {2'b01, (j == 0)});
      end
      bus1.fetch_done = (j == 0);
      bus1.stage_final = (j == 1) ? 3'b101 : 3'b000;
      tick();
    end
    bus1.fetch_done = 1'b0;
    bus1.stage_final = '0;
    vectors++;
    if ({bus1.error, bus1.busy, bus1.fetch_req, bus1.anchor_moving} !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL to_err cyc=%0d got err/busy/req/mov=%b, required 1000",
               cyc, {bus1.error, bus1.busy, bus1.fetch_req, bus1.anchor_moving});
    end
    tick();
    tick();
    vectors++;
    if ({bus1.error, bus1.busy} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL to_sticky cyc=%0d got err/busy=%b, required 10", cyc, {bus1.error, bus1.busy});
    end
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    vectors++;
    if ({bus1.error, bus1.busy, bus1.fetch_req, bus1.anchor_x, bus1.anchor_y, bus1.fetch_row, bus1.fetch_col} !==
        {3'b011, 128'd0}) begin
      miscompares++;
      $display("[TB] FAIL to_restart cyc=%0d got err/busy/req=%b pos=(%0d,%0d) row=%0d col=%0d, required 011 (0,0) 0 0",
               cyc, {bus1.error, bus1.busy, bus1.fetch_req}, bus1.anchor_x, bus1.anchor_y, bus1.fetch_row, bus1.fetch_col);
    end
    bus1.abort = 1'b1;
    tick();
    bus1.abort = 1'b0;
    vectors++;
    if ({bus1.busy, bus1.fetch_req} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL to_abort cyc=%0d got busy/req=%b, required 00", cyc, {bus1.busy, bus1.fetch_req});
    end
  endtask

  initial begin
    clear_inputs();
    $display("[TB] anchor_scheduler bench start");
    test_reset();
    test_frame_walk();
    test_out_of_order();
    test_slow_fetch();
    test_start_ignored();
    test_random();
    test_abort();
    test_reset_midframe();
    test_frame_walk();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/anchor_scheduler.md
Name: anchor_scheduler

Overview:
- Frame-level sequencer for the filter pipeline (blur and the downstream edge stages).
- Walks the anchor over the image in vertical strips, 16 output columns wide.
- Fetches each 20-pixel input line segment through a req/done handshake.
- Pulses anchor_moving, then waits until every filter stage reports final before the next move.
- Prefetches the next line while the stages process the current one.

Parameters:
- ROWS, 480: lines per strip; anchor_x range 0..ROWS-1.
- STRIPS, 40: strips per frame; anchor_y range 0..STRIPS-1.
- NUM_STAGES, 3: number of filter controllers whose final flags are gathered.
- TIMEOUT, 1023: maximum cycles spent waiting in PRIME or RUN before an error is raised.

Ports:
- clk  in  1  clock.
- n_rst  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  in  1  begin a frame; honoured only in IDLE or ERR.
- abort  in  1  synchronous abandon of the frame; returns the block to IDLE.
- stage_final  in  NUM_STAGES  final flags from the filter controllers (blur_final, ...).
- fetch_req  out  1  request the line segment at (fetch_row, fetch_col); level signal.
- fetch_row  out  32  line index of the requested segment.
- fetch_col  out  32  16*strip index of the requested segment.
- fetch_done  in  1  segment has been written to the filter input lines; counted only while fetch_req=1.
- anchor_moving  out  1  one-cycle pulse; filters start a new anchor.
- anchor_x  out  32  current line within the strip; 0 = first line of the strip.
- anchor_y  out  32  current strip index.
- busy  out  1  high in every state except IDLE and ERR.
- frame_done  out  1  one-cycle pulse when the last anchor completes.
- error  out  1  sticky timeout flag.

Behaviour:
- Reset (n_rst=0 at a rising edge): state IDLE; all outputs 0, including anchor_x/y and the fetch outputs. Clears all counters and the stage mask. Reset takes effect mid-frame with no drain.
- All outputs are registered.
- States: IDLE, PRIME, MOVE, HOLD, RUN, DONE, ERR.
- IDLE:
  - start=1 -> PRIME.
  - Position cleared to (0,0); error cleared.
- PRIME:
  - fetch_req=1, fetch_row=0, fetch_col=0.
  - fetch_done -> MOVE. fetch_req drops in the cycle after fetch_done is seen.
- MOVE: anchor_moving=1 for exactly one cycle; anchor_x/y already hold the new position. -> HOLD.
- HOLD:
  - Lasts one cycle; filters copy their input during this cycle.
  - Stage mask cleared; stage_final ignored here, because stages still read final=1 from their idle state.
  - -> RUN.
- RUN:
  - If the current anchor is not the last, fetch_req=1 for the next position (row/col computed as for advance below) until fetch_done. The fetch is then complete.
  - If the current anchor is the last, no fetch is issued and the fetch counts as complete.
  - mask |= stage_final each cycle, so single-cycle final pulses are retained.
  - When mask is all ones and the fetch is complete: last anchor -> DONE; otherwise advance the position and go to MOVE.
  - A fetch_done and the final stage bit arriving in the same cycle are both counted; the advance happens in the next cycle.
- Advance:
  - anchor_x+1.
  - If anchor_x = ROWS-1: anchor_x wraps to 0 and anchor_y+1.
  - Last anchor is (ROWS-1, STRIPS-1).
- DONE: frame_done=1 for one cycle -> IDLE. anchor_x/y hold the last position.
- Timeout:
  - Counter runs in PRIME and RUN and is cleared on entering either state.
  - Reaching TIMEOUT -> ERR: error=1, fetch_req=0.
  - ERR is left by start (-> PRIME, error cleared) or by abort (-> IDLE).
- abort:
  - Honoured in any busy state: next cycle is IDLE with fetch_req=0 and no frame_done.
  - Takes priority over every other transition in the same cycle.
- start while busy is ignored.
- fetch_done while fetch_req=0 is ignored.
- Latency:
  - start at cycle 0 -> fetch_req at cycle 1.
  - fetch_done at cycle k -> anchor_moving at cycle k+1.
  - Completion (mask full and fetch complete) in cycle m -> next anchor_moving, or frame_done, at cycle m+1.

Test Plan:
- Frame walk (ROWS=3, STRIPS=2; stages return final 5 cycles after HOLD; fetch_done 2 cycles after req) -> six anchor_moving pulses at (0,0),(1,0),(2,0),(0,1),(1,1),(2,1). fetch_col=16 for the strip-1 fetches. Exactly one frame_done, then busy=0.
- Stages finish out of order (bits pulsed single-cycle at RUN+2, +7, +4; stage_final held at all ones during HOLD) -> next anchor_moving exactly one cycle after the +7 bit; HOLD-cycle finals have no effect.
- Slow fetch (fetch_done 20 cycles after req, stages done at +3; extra fetch_done pulses injected while req=0) -> MOVE waits for the real fetch_done; stray pulses ignored; no fetch_req during the last anchor.
- Timeout (TIMEOUT=15, stage bit 1 never asserts) -> error=1 16 cycles after RUN entry, fetch_req=0; a later start clears error and restarts at (0,0).
- abort asserted during RUN at anchor (1,0) -> IDLE the next cycle, fetch_req=0, no frame_done. n_rst=0 mid-frame gives all outputs 0 on the next edge.
- start pulsed during RUN -> ignored; the frame sequence is unchanged.
